// File: rtl/ccff_chain_loader_if.sv
// ccff_chain_loader_if: valid/ready bitstream word channel from the config controller.
interface ccff_chain_loader_if #(parameter int WORD_W = 8);
    logic [WORD_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;
    modport master (output s_data, s_valid, input s_ready);
    modport slave  (input s_data, s_valid, output s_ready);
endinterface

// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: serialises config words LSB-first into a tile's ccff chain, with optional tail verify.
module ccff_chain_loader #(
    parameter int CHAIN_LEN = 36,
    parameter int WORD_W    = 8,
    parameter int ERR_W     = 8
) (
    input  logic              prog_clk,
    input  logic              prog_reset_n,
    input  logic              start,
    input  logic              verify,
    input  logic              abort,
    ccff_chain_loader_if.slave s,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ERR_W-1:0]  err_cnt
);
    localparam int BW = $clog2(CHAIN_LEN + 1);
    localparam int CW = $clog2(WORD_W + 1);
    localparam logic [BW-1:0] LAST = BW'(CHAIN_LEN - 1);
    typedef enum logic [1:0] {IDLE, FETCH, SHIFT, DONE} state_t;
    state_t state_q, state_d;
    logic [WORD_W-1:0] sreg_q, sreg_d;
    logic [CW-1:0] wcnt_q, wcnt_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic [ERR_W-1:0] cnt_d;
    logic mode_q, mode_d, head_d, err_d, mis;
    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            state_q       <= IDLE;
            sreg_q        <= '0;
            wcnt_q        <= '0;
            bcnt_q        <= '0;
            mode_q        <= 1'b0;
            ccff_head     <= 1'b0;
            ccff_shift_en <= 1'b0;
            err           <= 1'b0;
            err_cnt       <= '0;
        end else begin
            state_q       <= state_d;
            sreg_q        <= sreg_d;
            wcnt_q        <= wcnt_d;
            bcnt_q        <= bcnt_d;
            mode_q        <= mode_d;
            ccff_head     <= head_d;
            ccff_shift_en <= state_d == SHIFT;
            err           <= err_d;
            err_cnt       <= cnt_d;
        end
    end
    // head/shift_en are registered, so a SHIFT-state cycle is exactly the cycle the chain sees the bit
    assign mis = mode_q && state_q == SHIFT && ccff_tail != ccff_head;
    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        wcnt_d  = wcnt_q;
        bcnt_d  = bcnt_q;
        mode_d  = mode_q;
        head_d  = ccff_head;
        err_d   = err;
        cnt_d   = (mis && err_cnt != '1) ? err_cnt + 1'b1 : err_cnt;
        case (state_q)
            IDLE: if (start && !abort) begin
                state_d = FETCH;
                mode_d  = verify;
                err_d   = 1'b0;
                cnt_d   = '0;
                bcnt_d  = '0;
            end
            FETCH: if (s.s_valid) begin
                state_d = SHIFT;
                head_d  = s.s_data[0];
                sreg_d  = s.s_data >> 1;
                wcnt_d  = CW'(WORD_W);
            end
            SHIFT: begin
                head_d = sreg_q[0];
                sreg_d = sreg_q >> 1;
                wcnt_d = wcnt_q - 1'b1;
                bcnt_d = bcnt_q + 1'b1;
                if (bcnt_q == LAST) begin
                    state_d = DONE;
                    err_d   = mode_q && cnt_d != '0;
                end else if (wcnt_q == CW'(1)) begin
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
        if (abort) state_d = IDLE;
    end
    assign s.s_ready = state_q == FETCH;
    assign busy      = state_q != IDLE;
    assign done      = state_q == DONE;
endmodule

// File: tb/tb_ccff_chain_loader.sv
// tb_ccff_chain_loader: directed passes against a 36-bit external chain model.
module tb_ccff_chain_loader;
    logic clk = 0, rst_n = 0, start = 0, verify = 0, abort = 0;
    logic head, sh, tail, busy, done, err;
    logic [7:0] err_cnt;
    logic [35:0] chain = '0, heads;
    logic [7:0] words [5];
    int tests = 0, fails = 0;
    int shifts, hs, done_n, gaps_bad, last_sh, done_cyc, quiet;
    bit ended;
    logic err_done, err_c0;
    logic [7:0] cnt_c0;
    localparam logic [39:0] ORIG = 40'h09FF0F3CA5;
    localparam logic [39:0] INV  = 40'hF600F0C35A;
    localparam logic [39:0] FLIP = 40'h09FF0F3CA4;
    localparam logic [35:0] HEADS = 36'h9FF0F3CA5;

    ccff_chain_loader_if #(.WORD_W(8)) bus ();
    ccff_chain_loader dut (
        .prog_clk(clk), .prog_reset_n(rst_n), .start(start), .verify(verify), .abort(abort),
        .s(bus), .ccff_head(head), .ccff_shift_en(sh), .ccff_tail(tail),
        .busy(busy), .done(done), .err(err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;
    assign tail = chain[35];
    always @(posedge clk) if (sh) chain <= {chain[34:0], head};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_words(input logic [39:0] w);
        for (int i = 0; i < 5; i++) words[i] = w[8*i +: 8];
    endtask

    task automatic run_pass(input bit vfy, input bit sparse, input int abort_at, input int rst_at, input bit poke);
        int idx = 0;
        shifts = 0; hs = 0; done_n = 0; gaps_bad = 0; last_sh = -1; done_cyc = -1;
        ended = 0; heads = '0; err_done = 0;
        start = 1; verify = vfy;
        for (int cyc = 0; cyc < 300 && !ended; cyc++) begin
            @(negedge clk);
            start = 0; abort = 0;
            if (cyc == 0) begin err_c0 = err; cnt_c0 = err_cnt; end
            if (sh) begin
                if (shifts < 36) heads[shifts] = head;
                shifts++;
                last_sh = cyc;
            end else if (busy && !done && !bus.s_ready) gaps_bad++;
            if (done) begin done_n++; done_cyc = cyc; err_done = err; end
            if (!busy) ended = 1;
            else if (rst_at > 0 && shifts == rst_at) begin
                rst_n = 0;
                #1;
                check("reset_mid_outs", {bus.s_ready, head, sh, busy, done, err}, 0);
                check("reset_mid_cnt", err_cnt, 0);
                ended = 1;
            end else begin
                if (abort_at > 0 && shifts == abort_at) abort = 1;
                if (poke && shifts == 15) start = 1;
                bus.s_valid = sparse ? (cyc % 3 == 0) : 1'b1;
                bus.s_data = idx < 5 ? words[idx] : 8'h00;
                if (bus.s_valid && bus.s_ready) begin hs++; idx++; end
            end
        end
        bus.s_valid = 0;
        check("pass_terminated", ended, 1);
    endtask

    initial begin
        bus.s_valid = 0;
        bus.s_data = '0;
        #1;
        check("reset_outs", {bus.s_ready, head, sh, busy, done, err}, 0);
        check("reset_cnt", err_cnt, 0);
        @(negedge clk);
        rst_n = 1;
        // load pass, valid held high
        set_words(ORIG);
        run_pass(0, 0, 0, 0, 0);
        check("load_shifts", shifts, 36);
        check("load_heads", heads, HEADS);
        check("load_handshakes", hs, 5);
        check("load_done_once", done_n, 1);
        check("load_done_latency", done_cyc, last_sh + 1);
        check("load_err", err, 0);
        check("load_gaps", gaps_bad, 0);
        // verify against identical stream
        run_pass(1, 0, 0, 0, 0);
        check("vfy_ok_shifts", shifts, 36);
        check("vfy_ok_cnt", err_cnt, 0);
        check("vfy_ok_err", err_done, 0);
        // verify with every bit inverted
        set_words(INV);
        run_pass(1, 0, 0, 0, 0);
        check("vfy_inv_cnt", err_cnt, 36);
        check("vfy_inv_err_at_done", err_done, 1);
        check("vfy_inv_err_sticky", err, 1);
        // sparse valid plus a stray start mid-pass, reloading the original image
        set_words(ORIG);
        run_pass(0, 1, 0, 0, 1);
        check("sparse_shifts", shifts, 36);
        check("sparse_heads", heads, HEADS);
        check("sparse_handshakes", hs, 5);
        check("sparse_gaps", gaps_bad, 0);
        check("sparse_done_once", done_n, 1);
        check("sparse_err_cleared", err, 0);
        // single flipped bit
        set_words(FLIP);
        run_pass(1, 0, 0, 0, 0);
        check("vfy_flip_cnt", err_cnt, 1);
        check("vfy_flip_err_at_done", err_done, 1);
        // immediate restart: chain now holds the flipped image, original differs in bit 0
        set_words(ORIG);
        run_pass(1, 0, 0, 0, 0);
        check("restart_err_cleared", err_c0, 0);
        check("restart_cnt_cleared", cnt_c0, 0);
        check("restart_shifts", shifts, 36);
        check("restart_cnt", err_cnt, 1);
        // abort after 20 shifts of an all-mismatching verify
        set_words(INV);
        run_pass(1, 0, 20, 0, 0);
        check("abort_shifts", shifts, 20);
        check("abort_no_done", done_n, 0);
        check("abort_idle", {sh, bus.s_ready, busy}, 0);
        check("abort_cnt_hold", err_cnt, 20);
        check("abort_no_err", err, 0);
        // reset at bit 10
        run_pass(1, 0, 0, 10, 0);
        check("reset_at_shift", shifts, 10);
        quiet = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        repeat (5) begin
            @(negedge clk);
            if (sh || busy) quiet++;
        end
        check("reset_no_more_shift", quiet, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
